ram_burst_master: RTL and testbench

Initiator-side burst engine for one port of the multi-port solver RAM. It turns a single command (direction, base address, word count) into a sequence of per-cycle `address`/`data_write`/`WR_signal` drives. Write bursts stream from a valid/ready input; read bursts stream to a valid/ready output with backpressure. One instance sits between each ODE datapath unit and its RAM port, replacing hand-sequenced address/WR_signal control.

---
 rtl/ram_burst_pkg.sv | 21 ++
 rtl/burst_read_fifo.sv | 53 +++++
 rtl/ram_burst_master.sv | 175 +++++++++++++++++
 tb/tb_ram_burst_master.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_burst_pkg.sv
// Shared definitions for the RAM burst master: FSM state encoding and
// read-path sizing constants.
package ram_burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } burst_state_t;

  // Depth of the read-return FIFO; the issue credit limit is tied to it.
  localparam int RD_FIFO_DEPTH = 4;
  localparam int FIFO_PTR_WIDTH = $clog2(RD_FIFO_DEPTH);
  localparam int FIFO_COUNT_WIDTH = $clog2(RD_FIFO_DEPTH + 1);

  // Wide enough to hold fifo_count (0..4) plus in_flight (0..2).
  localparam int CREDIT_WIDTH = $clog2(RD_FIFO_DEPTH + 3);

endpackage

// File: rtl/burst_read_fifo.sv
// Small synchronous FIFO that buffers RAM read data (plus a last-beat flag)
// so the read stream can be backpressured without losing returned words.
module burst_read_fifo
  import ram_burst_pkg::*;
#(
  parameter int WIDTH = 65
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head,
  output logic [FIFO_COUNT_WIDTH-1:0] count,
  output logic                        empty
);

  logic [WIDTH-1:0]          mem [RD_FIFO_DEPTH];
  logic [FIFO_PTR_WIDTH-1:0] wr_ptr;
  logic [FIFO_PTR_WIDTH-1:0] rd_ptr;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

  // Storage array: written on push, no reset needed since count gates reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; reset discards any buffered words.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_PTR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_PTR_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + FIFO_COUNT_WIDTH'(1);
        2'b01:   count <= count - FIFO_COUNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ram_burst_master.sv
// Burst engine for one solver RAM port: converts a (direction, base, length)
// command into per-cycle address/data_write/WR_signal drives, streaming write
// data in and read data out through valid/ready handshakes.
module ram_burst_master
  import ram_burst_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 12,
  parameter int LEN_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] cmd_base,
  input  logic [LEN_WIDTH-1:0]     cmd_len,
  input  logic                     wr_data_valid,
  output logic                     wr_data_ready,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     rd_data_valid,
  input  logic                     rd_data_ready,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_data_last,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0]    data_write,
  output logic                     WR_signal,
  input  logic [DATA_WIDTH-1:0]    data_read
);

  burst_state_t                state;
  logic [ADDRESS_WIDTH-1:0]    base_q;
  logic [LEN_WIDTH-1:0]        len_q;
  logic [LEN_WIDTH-1:0]        k;
  logic                        rd_issue;
  logic                        rd_issue_last;
  logic                        rd_capture;
  logic                        rd_capture_last;
  logic [1:0]                  in_flight;
  logic [CREDIT_WIDTH-1:0]     credit_sum;
  logic                        credit_ok;
  logic [FIFO_COUNT_WIDTH-1:0] fifo_count;
  logic                        fifo_empty;
  logic [DATA_WIDTH:0]         fifo_head;
  logic                        rd_pop;
  logic                        wr_fire;
  logic                        k_is_last;
  logic [ADDRESS_WIDTH-1:0]    beat_address;

  // A read occupies one slot from the address cycle until it lands in the
  // FIFO, so issuing only while FIFO + in-flight < depth can never overflow.
  assign in_flight    = {1'b0, rd_issue} + {1'b0, rd_capture};
  assign credit_sum   = CREDIT_WIDTH'(fifo_count) + CREDIT_WIDTH'(in_flight);
  assign credit_ok    = credit_sum < CREDIT_WIDTH'(RD_FIFO_DEPTH);
  assign beat_address = base_q + ADDRESS_WIDTH'(k);
  assign k_is_last    = (k + LEN_WIDTH'(1)) == len_q;
  assign wr_fire      = wr_data_ready && wr_data_valid;

  assign rd_data_valid = !fifo_empty;
  assign rd_data       = fifo_head[DATA_WIDTH-1:0];
  assign rd_data_last  = fifo_head[DATA_WIDTH];
  assign rd_pop        = rd_data_valid && rd_data_ready;

  // Burst FSM with registered status and RAM-side drives.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cmd_ready     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      wr_data_ready <= 1'b0;
      address       <= '0;
      data_write    <= '0;
      WR_signal     <= 1'b0;
      base_q        <= '0;
      len_q         <= '0;
      k             <= '0;
      rd_issue      <= 1'b0;
      rd_issue_last <= 1'b0;
    end else begin
      WR_signal     <= 1'b0;
      done          <= 1'b0;
      rd_issue      <= 1'b0;
      rd_issue_last <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            base_q    <= cmd_base;
            len_q     <= cmd_len;
            k         <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_len == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else if (cmd_write) begin
              state         <= ST_WRITE;
              wr_data_ready <= 1'b1;
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_WRITE: begin
          if (k == len_q) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else if (wr_fire) begin
            address    <= beat_address;
            data_write <= wr_data;
            WR_signal  <= 1'b1;
            k          <= k + LEN_WIDTH'(1);
            if (k_is_last) begin
              wr_data_ready <= 1'b0;
            end
          end
        end
        ST_READ: begin
          if (credit_ok) begin
            address       <= beat_address;
            rd_issue      <= 1'b1;
            rd_issue_last <= k_is_last;
            k             <= k + LEN_WIDTH'(1);
            if (k_is_last) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (rd_pop && rd_data_last && (in_flight == 2'd0)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  // Read return pipeline: data_read is valid the cycle after the address cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_capture      <= 1'b0;
      rd_capture_last <= 1'b0;
    end else begin
      rd_capture      <= rd_issue;
      rd_capture_last <= rd_issue_last;
    end
  end

  burst_read_fifo #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_read_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_capture),
    .push_data ({rd_capture_last, data_read}),
    .pop       (rd_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural synchronous RAM
// attached to the port side.
module tb_ram_burst_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [11:0] cmd_base;
  logic [7:0]  cmd_len;
  logic        wr_data_valid;
  logic        wr_data_ready;
  logic [63:0] wr_data;
  logic        rd_data_valid;
  logic        rd_data_ready;
  logic [63:0] rd_data;
  logic        rd_data_last;
  logic        busy;
  logic        done;
  logic [11:0] address;
  logic [63:0] data_write;
  logic        WR_signal;
  logic [63:0] data_read;

  int total;
  int bad;
  int cycle;
  int acceptCycle;
  int doneCycle;
  int doneCount;
  int rdValidCount;
  int maxFifo;

  logic [11:0] wrAddr[$];
  logic [63:0] wrData[$];
  int          wrCycle[$];
  logic [63:0] rdData[$];
  logic        rdLast[$];
  int          rdCycle[$];

  logic [63:0] ram [4096];
  logic [63:0] ramOut;
  logic [63:0] wdata [8];
  logic [63:0] rexp [8];
  bit          vpat [8];
  bit          rpat [8];
  int          patLen;

  ram_burst_master dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_base      (cmd_base),
    .cmd_len       (cmd_len),
    .wr_data_valid (wr_data_valid),
    .wr_data_ready (wr_data_ready),
    .wr_data       (wr_data),
    .rd_data_valid (rd_data_valid),
    .rd_data_ready (rd_data_ready),
    .rd_data       (rd_data),
    .rd_data_last  (rd_data_last),
    .busy          (busy),
    .done          (done),
    .address       (address),
    .data_write    (data_write),
    .WR_signal     (WR_signal),
    .data_read     (data_read)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to time-stamp observed events.
  always @(posedge clk) begin
    cycle = cycle + 1;
  end

  // Behavioural RAM: write on WR_signal, registered read data one cycle later.
  always @(posedge clk) begin
    ramOut <= ram[address];
    if (WR_signal) begin
      ram[address] = data_write;
    end
  end
  assign data_read = ramOut;

  // Event monitor, sampling on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (WR_signal) begin
      wrAddr.push_back(address);
      wrData.push_back(data_write);
      wrCycle.push_back(cycle);
    end
    if (done) begin
      doneCount = doneCount + 1;
      doneCycle = cycle;
      checkOutput("done_with_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    if (rd_data_valid) begin
      rdValidCount = rdValidCount + 1;
    end
    if (rd_data_valid && rd_data_ready) begin
      rdData.push_back(rd_data);
      rdLast.push_back(rd_data_last);
      rdCycle.push_back(cycle);
    end
    if (int'(dut.u_read_fifo.count) > maxFifo) begin
      maxFifo = int'(dut.u_read_fifo.count);
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total = total + 1;
    if (actual !== expected) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issueCommand(input logic wr, input logic [11:0] base, input logic [7:0] len);
    int n;
    wrAddr.delete(); wrData.delete(); wrCycle.delete();
    rdData.delete(); rdLast.delete(); rdCycle.delete();
    doneCount = 0; doneCycle = -1; rdValidCount = 0; maxFifo = 0;
    n = 0;
    while (!cmd_ready && n < 100) begin
      step();
      n++;
    end
    if (!cmd_ready) checkOutput("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_base = base;
    cmd_len = len;
    acceptCycle = cycle;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic wr, input logic [11:0] base, input logic [7:0] len);
    int  beat;
    int  idx;
    bit  finished;
    issueCommand(wr, base, len);
    beat = 0;
    idx = 0;
    finished = 1'b0;
    for (int n = 0; n < 300 && !finished; n++) begin
      if (wr) begin
        wr_data_valid = vpat[idx % patLen];
        wr_data = wdata[beat % 8];
        if (wr_data_ready && wr_data_valid) beat++;
      end else begin
        rd_data_ready = rpat[idx % patLen];
      end
      idx++;
      if (done) finished = 1'b1;
      step();
    end
    wr_data_valid = 1'b0;
    rd_data_ready = 1'b0;
    if (!finished) checkOutput("done_timeout", 64'(finished), 64'd1);
  endtask

  task automatic checkWriteLog(input string tag, input logic [11:0] base, input int n);
    logic [11:0] ea;
    checkOutput({tag, "_wr_count"}, 64'(wrAddr.size()), 64'(n));
    for (int i = 0; i < n && i < wrAddr.size(); i++) begin
      ea = base + 12'(i);
      checkOutput({tag, "_wr_addr"}, 64'(wrAddr[i]), 64'(ea));
      checkOutput({tag, "_wr_data"}, wrData[i], wdata[i]);
    end
  endtask

  task automatic checkReadLog(input string tag, input int n);
    checkOutput({tag, "_rd_count"}, 64'(rdData.size()), 64'(n));
    for (int i = 0; i < n && i < rdData.size(); i++) begin
      checkOutput({tag, "_rd_data"}, rdData[i], rexp[i]);
      checkOutput({tag, "_rd_last"}, 64'(rdLast[i]), 64'(i == n - 1));
    end
  endtask

  initial begin
    total = 0; bad = 0; cycle = 0;
    doneCount = 0; doneCycle = -1; rdValidCount = 0; maxFifo = 0;
    for (int i = 0; i < 4096; i++) ram[i] = 64'hA5A5_0000_0000_0000 + 64'(i);
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_base = '0; cmd_len = '0;
    wr_data_valid = 1'b0; wr_data = '0; rd_data_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vpat[i] = 1'b1;
      rpat[i] = 1'b1;
    end
    patLen = 1;

    step();
    step();
    rst = 1'b0;
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_wr_data_ready", 64'(wr_data_ready), 64'd0);
    checkOutput("rst_rd_data_valid", 64'(rd_data_valid), 64'd0);
    checkOutput("rst_rd_data_last", 64'(rd_data_last), 64'd0);
    checkOutput("rst_address", 64'(address), 64'd0);
    checkOutput("rst_data_write", data_write, 64'd0);
    checkOutput("rst_WR_signal", 64'(WR_signal), 64'd0);

    // Write len=4 at 0x010, valid held high.
    wdata[0] = 64'h1110a716aa948111;
    wdata[1] = 64'h1110a716aa948112;
    wdata[2] = 64'h1110a716aa948113;
    wdata[3] = 64'h1110a716aa948114;
    applyStimulus(1'b1, 12'h010, 8'd4);
    checkWriteLog("t1", 12'h010, 4);
    for (int i = 0; i < 4 && i < wrCycle.size(); i++)
      checkOutput("t1_wr_cycle", 64'(wrCycle[i]), 64'(acceptCycle + 2 + i));
    checkOutput("t1_done_cycle", 64'(doneCycle), 64'(acceptCycle + 6));
    checkOutput("t1_done_count", 64'(doneCount), 64'd1);
    checkOutput("t1_cmd_ready_after", 64'(cmd_ready), 64'd1);
    checkOutput("t1_busy_after", 64'(busy), 64'd0);

    // Read back len=4 from 0x010 with ready held high.
    for (int i = 0; i < 4; i++) rexp[i] = wdata[i];
    applyStimulus(1'b0, 12'h010, 8'd4);
    checkReadLog("t1r", 4);
    for (int i = 0; i < 4 && i < rdCycle.size(); i++)
      checkOutput("t1r_rd_cycle", 64'(rdCycle[i]), 64'(acceptCycle + 4 + i));
    checkOutput("t1r_done_cycle", 64'(doneCycle), 64'(acceptCycle + 8));
    checkOutput("t1r_no_wr", 64'(wrAddr.size()), 64'd0);

    // Write len=4 across the address wrap at 0xFFE, then read back.
    wdata[0] = 64'hCAFE0000DEAD0000;
    wdata[1] = 64'hCAFE0000DEAD0001;
    wdata[2] = 64'hCAFE0000DEAD0002;
    wdata[3] = 64'hCAFE0000DEAD0003;
    applyStimulus(1'b1, 12'hFFE, 8'd4);
    checkWriteLog("t2", 12'hFFE, 4);
    if (wrAddr.size() == 4) begin
      checkOutput("t2_wrap_addr2", 64'(wrAddr[2]), 64'h000);
      checkOutput("t2_wrap_addr3", 64'(wrAddr[3]), 64'h001);
    end
    for (int i = 0; i < 4; i++) rexp[i] = wdata[i];
    applyStimulus(1'b0, 12'hFFE, 8'd4);
    checkReadLog("t2r", 4);

    // Read len=8 from 0x010 with ready toggling 1,0,0,1.
    rpat[0] = 1'b1; rpat[1] = 1'b0; rpat[2] = 1'b0; rpat[3] = 1'b1;
    patLen = 4;
    rexp[0] = 64'h1110a716aa948111;
    rexp[1] = 64'h1110a716aa948112;
    rexp[2] = 64'h1110a716aa948113;
    rexp[3] = 64'h1110a716aa948114;
    rexp[4] = 64'hA5A5000000000014;
    rexp[5] = 64'hA5A5000000000015;
    rexp[6] = 64'hA5A5000000000016;
    rexp[7] = 64'hA5A5000000000017;
    applyStimulus(1'b0, 12'h010, 8'd8);
    checkReadLog("t3", 8);
    checkOutput("t3_fifo_peak_le4", 64'(maxFifo <= 4), 64'd1);
    for (int i = 0; i < 8; i++) rpat[i] = 1'b1;

    // Write len=3 at 0x000 with valid pattern 1,0,1,0,0,1.
    vpat[0] = 1'b1; vpat[1] = 1'b0; vpat[2] = 1'b1;
    vpat[3] = 1'b0; vpat[4] = 1'b0; vpat[5] = 1'b1;
    patLen = 6;
    wdata[0] = 64'h3000;
    wdata[1] = 64'h3001;
    wdata[2] = 64'h3002;
    applyStimulus(1'b1, 12'h000, 8'd3);
    checkWriteLog("t4", 12'h000, 3);
    if (wrCycle.size() == 3) begin
      checkOutput("t4_wr_cycle0", 64'(wrCycle[0]), 64'(acceptCycle + 2));
      checkOutput("t4_wr_cycle1", 64'(wrCycle[1]), 64'(acceptCycle + 4));
      checkOutput("t4_wr_cycle2", 64'(wrCycle[2]), 64'(acceptCycle + 7));
    end
    checkOutput("t4_done_cycle", 64'(doneCycle), 64'(acceptCycle + 8));
    for (int i = 0; i < 8; i++) vpat[i] = 1'b1;
    patLen = 1;

    // Zero-length commands in both directions.
    applyStimulus(1'b1, 12'h100, 8'd0);
    checkOutput("t5w_done_cycle", 64'(doneCycle), 64'(acceptCycle + 1));
    checkOutput("t5w_no_wr", 64'(wrAddr.size()), 64'd0);
    applyStimulus(1'b0, 12'h100, 8'd0);
    repeat (3) step();
    checkOutput("t5r_done_cycle", 64'(doneCycle), 64'(acceptCycle + 1));
    checkOutput("t5r_no_rd_valid", 64'(rdValidCount), 64'd0);
    checkOutput("t5r_no_wr", 64'(wrAddr.size()), 64'd0);

    // Reset after the 2nd of 6 write beats at 0x020.
    for (int i = 0; i < 6; i++) wdata[i] = 64'h00000000F00D0000 + 64'(i);
    issueCommand(1'b1, 12'h020, 8'd6);
    wr_data_valid = 1'b1;
    wr_data = wdata[0];
    step();
    wr_data = wdata[1];
    step();
    wr_data = wdata[2];
    rst = 1'b1;
    step();
    rst = 1'b0;
    wr_data_valid = 1'b0;
    checkOutput("t6_WR_signal", 64'(WR_signal), 64'd0);
    checkOutput("t6_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("t6_busy", 64'(busy), 64'd0);
    checkOutput("t6_wr_data_ready", 64'(wr_data_ready), 64'd0);
    repeat (8) step();
    checkOutput("t6_no_done", 64'(doneCount), 64'd0);
    checkWriteLog("t6", 12'h020, 2);
    rexp[0] = wdata[0];
    rexp[1] = wdata[1];
    applyStimulus(1'b0, 12'h020, 8'd2);
    checkReadLog("t6r", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
